matvec_arbiter: RTL and testbench

Job-level arbiter that shares one matvec8 engine (K×K weight matrix, K-element vector, K saturated 28-bit results) among NREQ requesters. Grants the engine round-robin for one whole job (optional matrix load plus vector, then K results), muxes the winner's input stream into the engine, and routes the engine's output stream back to that requester only. Sits between the requester ports and the engine's input/output handshakes, and tracks which requester's matrix is resident in the engine.

---
 rtl/matvec_pkg.sv | 26 ++
 rtl/matvec_arbiter_rr_picker.sv | 34 +++
 rtl/matvec_arbiter.sv | 162 ++++++++++++++++
 tb/tb_matvec_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared types and constants for the matvec engine arbiter
//
// Purpose: arbiter FSM state encoding, default engine geometry and job-length
// helpers shared by matvec_arbiter and its round-robin picker.
// Ports: none (package).
package matvec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int K_DEFAULT  = 8;
  localparam int IW_DEFAULT = 14;
  localparam int OW_DEFAULT = 28;

  localparam int JOB_LEN_MATRIX_DEFAULT = K_DEFAULT * K_DEFAULT + K_DEFAULT;
  localparam int JOB_LEN_VECTOR_DEFAULT = K_DEFAULT;

  // Input words in one job: matrix (k*k) plus vector (k), or vector only.
  function automatic int job_words(input int k, input logic new_matrix);
    return new_matrix ? (k * k + k) : k;
  endfunction

endpackage

// File: rtl/matvec_arbiter_rr_picker.sv
// rtl/matvec_arbiter_rr_picker.sv - combinational round-robin first-eligible search
//
// Purpose: finds the first set bit of eligible at or after ptr, wrapping.
// Ports:
//   eligible   in  N   per-requester eligibility
//   ptr        in  PW  search start index
//   idx        out PW  selected requester (0 when none)
//   any_valid  out 1   at least one requester eligible
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          any_valid
);

  function automatic int wrap_index(input int base, input int offset);
    return (base + offset) % N;
  endfunction

  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_valid && eligible[wrap_index(int'(ptr), k)]) begin
        any_valid = 1'b1;
        idx       = PW'(wrap_index(int'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/matvec_arbiter.sv
// rtl/matvec_arbiter.sv - job-level round-robin arbiter sharing one matvec engine
//
// Purpose: grants the engine to one requester for a whole job (optional K*K
// matrix plus K vector words in, K results out), muxes that requester's input
// stream to the engine and routes results back to it, and tracks whose matrix
// is resident in the engine.
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_data/req_new_matrix/req_ready   requester input side
//   res_valid/res_data/res_ready                  requester result side
//   eng_input_*, eng_new_matrix                   engine input side
//   eng_output_*                                  engine output side
//   busy, owner, matrix_loaded, matrix_owner, job_done   status
module matvec_arbiter
  import matvec_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int K    = K_DEFAULT,
  parameter int IW   = IW_DEFAULT,
  parameter int OW   = OW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0][IW-1:0]  req_data,
  input  logic [NREQ-1:0]          req_new_matrix,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          res_valid,
  output logic [OW-1:0]            res_data,
  input  logic [NREQ-1:0]          res_ready,
  output logic                     eng_input_valid,
  input  logic                     eng_input_ready,
  output logic [IW-1:0]            eng_input_data,
  output logic                     eng_new_matrix,
  input  logic                     eng_output_valid,
  output logic                     eng_output_ready,
  input  logic [OW-1:0]            eng_output_data,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     matrix_loaded,
  output logic [$clog2(NREQ)-1:0]  matrix_owner,
  output logic                     job_done
);

  localparam int PW  = $clog2(NREQ);
  localparam int WCW = $clog2(K * K + K + 1);
  localparam int RCW = $clog2(K + 1);
  localparam logic [WCW-1:0] LEN_MATRIX = WCW'(job_words(K, 1'b1));
  localparam logic [WCW-1:0] LEN_VECTOR = WCW'(job_words(K, 1'b0));

  state_t          state, state_next;
  logic [PW-1:0]   rr_ptr;
  logic            nm;
  logic [WCW-1:0]  job_len;
  logic [WCW-1:0]  word_cnt;
  logic [RCW-1:0]  result_cnt;

  logic [NREQ-1:0] eligible;
  logic [PW-1:0]   pick;
  logic            pick_any;
  logic            in_xfer, last_word;
  logic            out_xfer, last_result;

  // A vector-only job is only meaningful against the requester's own matrix.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] &&
                    (req_new_matrix[i] || (matrix_loaded && matrix_owner == PW'(i)));
    end
  end

  rr_picker #(.N(NREQ), .PW(PW)) u_picker (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .idx       (pick),
    .any_valid (pick_any)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_next       = state;
    req_ready        = '0;
    res_valid        = '0;
    res_data         = '0;
    eng_input_valid  = 1'b0;
    eng_input_data   = '0;
    eng_new_matrix   = 1'b0;
    eng_output_ready = 1'b0;
    in_xfer          = 1'b0;
    last_word        = 1'b0;
    out_xfer         = 1'b0;
    last_result      = 1'b0;
    job_done         = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) state_next = LOAD;
      end
      LOAD: begin
        eng_input_valid  = req_valid[owner];
        eng_input_data   = req_data[owner];
        eng_new_matrix   = nm;
        req_ready[owner] = eng_input_ready;
        in_xfer          = req_valid[owner] && eng_input_ready;
        last_word        = in_xfer && (word_cnt == job_len - WCW'(1));
        if (last_word) state_next = DRAIN;
      end
      DRAIN: begin
        res_valid[owner] = eng_output_valid;
        res_data         = eng_output_data;
        eng_output_ready = res_ready[owner];
        out_xfer         = eng_output_valid && res_ready[owner];
        last_result      = out_xfer && (result_cnt == RCW'(K - 1));
        job_done         = last_result;
        if (last_result) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      matrix_loaded <= 1'b0;
      matrix_owner  <= '0;
      nm            <= 1'b0;
      job_len       <= '0;
      word_cnt      <= '0;
      result_cnt    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner      <= pick;
            nm         <= req_new_matrix[pick];
            job_len    <= req_new_matrix[pick] ? LEN_MATRIX : LEN_VECTOR;
            word_cnt   <= '0;
            result_cnt <= '0;
          end
        end
        LOAD: begin
          if (in_xfer) word_cnt <= word_cnt + WCW'(1);
          // Residency changes only once the whole matrix has gone in.
          if (last_word && nm) begin
            matrix_owner  <= owner;
            matrix_loaded <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_xfer) result_cnt <= result_cnt + RCW'(1);
          if (last_result) rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_arbiter.sv
// tb/tb_matvec_arbiter.sv - scoreboard bench for matvec_arbiter with a behavioural engine
module tb_matvec_arbiter;
  import matvec_pkg::*;

  localparam int NREQ = 4;
  localparam int K    = 8;
  localparam int IW   = 14;
  localparam int OW   = 28;
  localparam int MAXW = K * K + K;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0][IW-1:0] req_data = '0;
  logic [NREQ-1:0]         req_new_matrix = '0;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         res_valid;
  logic [OW-1:0]           res_data;
  logic [NREQ-1:0]         res_ready = '0;
  logic                    eng_input_valid;
  logic                    eng_input_ready = 1'b0;
  logic [IW-1:0]           eng_input_data;
  logic                    eng_new_matrix;
  logic                    eng_output_valid = 1'b0;
  logic                    eng_output_ready;
  logic [OW-1:0]           eng_output_data = '0;
  logic                    busy;
  logic [1:0]              owner;
  logic                    matrix_loaded;
  logic [1:0]              matrix_owner;
  logic                    job_done;

  always #5 clk = ~clk;

  matvec_arbiter #(.NREQ(NREQ), .K(K), .IW(IW), .OW(OW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_new_matrix(req_new_matrix),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .eng_input_valid(eng_input_valid), .eng_input_ready(eng_input_ready),
    .eng_input_data(eng_input_data), .eng_new_matrix(eng_new_matrix),
    .eng_output_valid(eng_output_valid), .eng_output_ready(eng_output_ready),
    .eng_output_data(eng_output_data),
    .busy(busy), .owner(owner), .matrix_loaded(matrix_loaded),
    .matrix_owner(matrix_owner), .job_done(job_done)
  );

  int tests = 0;
  int fails = 0;
  bit rnd = 0, skip_in = 0, watch2 = 0, watch3 = 0;
  int in_words = 0, res_words = 0, done_cnt = 0, done_exp = 0, viol2 = 0, viol3 = 0;

  logic [IW:0]   ei[$];   // {new_matrix, word} expected at the engine input
  int            er[$];   // expected requester of each result
  logic [OW-1:0] ev[$];   // expected result value

  logic [IW-1:0] jw[NREQ][MAXW];
  int            jn[NREQ];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Builds job words for requester r and pushes the hand-derived expectations.
  // scale==0 means an all-ones matrix (every result = sum of vector),
  // otherwise scale*I (result i = scale*v[i]). vk 0: v=1..8, vk 1: v=8..1.
  task automatic prep(input int r, input bit nm, input int scale, input int vk);
    int v[K];
    int sum = 0;
    jn[r] = 0;
    for (int i = 0; i < K; i++) begin
      v[i] = (vk == 0) ? i + 1 : K - i;
      sum += v[i];
    end
    if (nm) begin
      for (int rr = 0; rr < K; rr++) begin
        for (int cc = 0; cc < K; cc++) begin
          jw[r][jn[r]] = IW'((scale == 0) ? 1 : ((rr == cc) ? scale : 0));
          ei.push_back({1'b1, jw[r][jn[r]]});
          jn[r]++;
        end
      end
    end
    for (int i = 0; i < K; i++) begin
      jw[r][jn[r]] = IW'(v[i]);
      ei.push_back({nm, jw[r][jn[r]]});
      jn[r]++;
    end
    for (int i = 0; i < K; i++) begin
      er.push_back(r);
      ev.push_back(OW'((scale == 0) ? sum : scale * v[i]));
    end
    done_exp++;
  endtask

  task automatic send_job(input int r, input bit nm);
    bit acc;
    int t;
    req_new_matrix[r] = nm;
    for (int k = 0; k < jn[r]; k++) begin
      if (rnd && $urandom_range(0, 2) == 0) begin
        req_valid[r] = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      req_data[r]  = jw[r][k];
      req_valid[r] = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        acc = req_valid[r] && req_ready[r];
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 20000);
      if (!acc) begin
        chk("send_accept", acc, 1);
        break;
      end
    end
    req_valid[r]      = 1'b0;
    req_new_matrix[r] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while ((ei.size() != 0 || er.size() != 0 || busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_completes"}, (t < 20000), 1);
    chk({name, "_job_done_count"}, done_cnt, done_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Behavioural engine: collects a job, computes saturated products, returns K results.
  initial begin : engine
    logic [IW-1:0] mat[K][K];
    logic [IW-1:0] vec[K];
    logic [OW-1:0] eres[K];
    int  e_cnt = 0, e_len = 0, e_ridx = 0;
    bit  e_nm = 0, e_out = 0;
    bit  in_x, out_x, rst, nmb;
    logic [IW-1:0] d;
    longint s;
    forever begin
      @(negedge clk);
      in_x  = eng_input_valid && eng_input_ready;
      out_x = eng_output_valid && eng_output_ready;
      d     = eng_input_data;
      nmb   = eng_new_matrix;
      rst   = !reset;
      @(posedge clk);
      #1;
      if (rst) begin
        e_cnt = 0; e_out = 0; e_ridx = 0;
      end else begin
        if (in_x) begin
          if (e_cnt == 0) begin
            e_nm  = nmb;
            e_len = nmb ? K * K + K : K;
          end
          if (e_nm && e_cnt < K * K) mat[e_cnt / K][e_cnt % K] = d;
          else vec[e_cnt - (e_nm ? K * K : 0)] = d;
          e_cnt++;
          if (e_cnt == e_len) begin
            for (int r = 0; r < K; r++) begin
              s = 0;
              for (int c = 0; c < K; c++)
                s += longint'($signed(mat[r][c])) * longint'($signed(vec[c]));
              if (s > 134217727) s = 134217727;
              if (s < -134217728) s = -134217728;
              eres[r] = OW'(s);
            end
            e_cnt = 0; e_out = 1; e_ridx = 0;
          end
        end
        if (out_x) begin
          e_ridx++;
          if (e_ridx == K) begin
            e_out = 0; e_ridx = 0;
          end
        end
      end
      eng_input_ready  = !e_out && (!rnd || $urandom_range(0, 3) != 0);
      eng_output_valid = e_out && (!rnd || $urandom_range(0, 2) != 0);
      eng_output_data  = e_out ? eres[e_ridx] : '0;
      res_ready        = rnd ? NREQ'($urandom) : '1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT moves a word.
  always @(negedge clk) begin
    logic [IW:0] e;
    if (reset) begin
      if (eng_input_valid && eng_input_ready && !skip_in) begin
        in_words++;
        if (ei.size() == 0) chk("in_word_expected", ei.size(), 1);
        else begin
          e = ei.pop_front();
          chk("in_data", eng_input_data, e[IW-1:0]);
          chk("in_new_matrix", eng_new_matrix, e[IW]);
        end
      end
      if (res_valid != '0) chk("res_valid_owner_only", res_valid, 1 << owner);
      for (int i = 0; i < NREQ; i++) begin
        if (res_valid[i] && res_ready[i]) begin
          res_words++;
          if (er.size() == 0) chk("res_expected", er.size(), 1);
          else begin
            chk("res_requester", i, er.pop_front());
            chk("res_data", res_data, ev.pop_front());
          end
        end
      end
      if (job_done) done_cnt++;
      if (watch2 && busy && owner == 2'd1 && req_ready[2]) viol2++;
      if (watch3 && req_ready[3]) viol3++;
    end
  end

  initial begin : main
    int iw0, rw0, n, t;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_owner", owner, 0);
    chk("reset_matrix_loaded", matrix_loaded, 0);
    chk("reset_matrix_owner", matrix_owner, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_eng_input_valid", eng_input_valid, 0);
    chk("reset_eng_output_ready", eng_output_ready, 0);
    chk("reset_job_done", job_done, 0);
    @(posedge clk);
    #1;

    // Requester 0 loads identity, vector 1..8.
    prep(0, 1, 1, 0);
    send_job(0, 1);
    wait_idle("t1");
    chk("t1_in_words", in_words, 72);
    chk("t1_res_words", res_words, 8);
    chk("t1_matrix_loaded", matrix_loaded, 1);
    chk("t1_matrix_owner", matrix_owner, 0);

    // From rr_ptr=0, requesters 1 and 2 both eligible: 1 first, then 2.
    do_reset();
    @(negedge clk);
    chk("t2_reset_forgets_matrix", matrix_loaded, 0);
    @(posedge clk);
    #1;
    prep(1, 1, 2, 0);
    prep(2, 1, 0, 0);
    watch2 = 1;
    fork
      send_job(1, 1);
      send_job(2, 1);
    join
    wait_idle("t2");
    watch2 = 0;
    chk("t2_req2_held_during_job1", viol2, 0);
    chk("t2_matrix_owner", matrix_owner, 2);

    // Requester 3 vector-only stays pending; requester 0 loads then runs vector-only.
    watch3 = 1;
    req_new_matrix[3] = 1'b0;
    req_data[3]       = IW'(5);
    req_valid[3]      = 1'b1;
    prep(0, 1, 3, 0);
    send_job(0, 1);
    prep(0, 0, 3, 1);
    send_job(0, 0);
    wait_idle("t3");
    chk("t3_req3_never_accepted", viol3, 0);
    chk("t3_matrix_owner", matrix_owner, 0);
    req_valid[3] = 1'b0;
    watch3 = 0;

    // Random stalls on every handshake.
    rnd = 1;
    iw0 = in_words;
    rw0 = res_words;
    prep(1, 1, 0, 0);
    send_job(1, 1);
    prep(1, 0, 0, 1);
    send_job(1, 0);
    wait_idle("t4");
    rnd = 0;
    chk("t4_in_words", in_words - iw0, 80);
    chk("t4_res_words", res_words - rw0, 16);
    chk("t4_matrix_owner", matrix_owner, 1);

    // Reset at word 30 of a matrix load.
    skip_in = 1;
    req_new_matrix[2] = 1'b1;
    req_valid[2]      = 1'b1;
    n = 0;
    t = 0;
    while (n < 30 && t < 2000) begin
      req_data[2] = IW'(100 + n);
      @(negedge clk);
      if (req_ready[2]) n++;
      @(posedge clk);
      #1;
      t++;
    end
    chk("t5_words_before_reset", n, 30);
    chk("t5_matrix_loaded_before_reset", matrix_loaded, 1);
    req_valid[2]      = 1'b0;
    req_new_matrix[2] = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_matrix_loaded", matrix_loaded, 0);
    chk("t5_req_ready", req_ready, 0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_eng_input_valid", eng_input_valid, 0);
    chk("t5_eng_output_ready", eng_output_ready, 0);
    @(posedge clk);
    #1;
    skip_in = 0;
    prep(3, 1, 1, 0);
    send_job(3, 1);
    wait_idle("t5_fresh");
    chk("t5_matrix_owner", matrix_owner, 3);
    chk("t5_matrix_loaded_after", matrix_loaded, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
